// File: rtl/mux2_pkg.sv
// Shared constants and helpers for the mux2 selector.
// Default widths and the saturating increment used by the select-toggle counter.
package mux2_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;
  localparam int unsigned DEFAULT_CNT_W = 8;

  // Widest counter the helper supports; callers zero-extend into this width.
  localparam int unsigned MAX_CNT_W = 32;

  // Add one to the low w bits of v, holding at 2^w-1 instead of wrapping.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                   input int unsigned       w);
    logic [MAX_CNT_W:0] lim;
    lim = ((MAX_CNT_W+1)'(1) << w) - (MAX_CNT_W+1)'(1);
    if ({1'b0, v} >= lim) begin
      return lim[MAX_CNT_W-1:0];
    end
    return v + MAX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/mux2_bit.sv
// Single-bit two-way select; the building block replicated across the mux2 datapath.
module mux2_bit (
  input  logic a0,
  input  logic a1,
  input  logic sel,
  output logic y
);

  assign y = sel ? a1 : a0;

endmodule

// File: rtl/mux2.sv
// WIDTH-bit two-input selector with combinational and registered outputs.
// Define MUX2_SWITCH_CNT_EN to add the saturating select-toggle counter sw_cnt.
module mux2
  import mux2_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             j,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_q
`ifdef MUX2_SWITCH_CNT_EN
  ,
  output logic [CNT_W-1:0] sw_cnt
`endif
);

  // Reject configurations the datapath and counter helper cannot represent.
  if (WIDTH < 1) begin : g_bad_width
    $error("mux2: WIDTH must be at least 1");
  end
  if (CNT_W < 1 || CNT_W > MAX_CNT_W) begin : g_bad_cnt_w
    $error("mux2: CNT_W out of supported range");
  end

  // Combinational select, one bit slice per data bit.
  for (genvar b = 0; b < int'(WIDTH); b++) begin : g_bit
    mux2_bit u_bit (
      .a0  (i0[b]),
      .a1  (i1[b]),
      .sel (j),
      .y   (o[b])
    );
  end

  // Registered copy of the selected value.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q <= '0;
    end else begin
      o_q <= o;
    end
  end

`ifdef MUX2_SWITCH_CNT_EN
  logic j_q;

  // Count edges where the select differs from its previous sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      j_q    <= 1'b0;
      sw_cnt <= '0;
    end else begin
      j_q <= j;
      if (j != j_q) begin
        sw_cnt <= CNT_W'(sat_inc(MAX_CNT_W'(sw_cnt), CNT_W));
      end
    end
  end
`endif

endmodule

// File: tb/tb_mux2.sv
// Self-checking bench for mux2: directed plan steps followed by randomized cycles
// against a behavioural model (selection by array index, counter as a clamped integer).
module tb_mux2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       n_i0 = 1'b0, n_i1 = 1'b0, n_j = 1'b0;
  logic       n_o, n_o_q;

  logic [7:0] w_i0 = '0, w_i1 = '0;
  logic       w_j = 1'b0;
  logic [7:0] w_o, w_o_q;

`ifdef MUX2_SWITCH_CNT_EN
  logic [7:0] n_sw_cnt;
  logic [1:0] w_sw_cnt;
`endif

  int unsigned checks = 0;
  int unsigned passes = 0;

  // Model state for the 8-bit instance.
  logic [7:0] exp_q = '0;
  int         cnt_m = 0;
  logic       jq_m  = 1'b0;
  localparam int CNT_MAX = 3;

  mux2 #(.WIDTH(1), .CNT_W(8)) u_narrow (
    .clk (clk), .rst (rst), .i0 (n_i0), .i1 (n_i1), .j (n_j),
    .o   (n_o), .o_q (n_o_q)
`ifdef MUX2_SWITCH_CNT_EN
    , .sw_cnt (n_sw_cnt)
`endif
  );

  mux2 #(.WIDTH(8), .CNT_W(2)) u_wide (
    .clk (clk), .rst (rst), .i0 (w_i0), .i1 (w_i1), .j (w_j),
    .o   (w_o), .o_q (w_o_q)
`ifdef MUX2_SWITCH_CNT_EN
    , .sw_cnt (w_sw_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  function automatic logic [7:0] pick(input logic [7:0] a, input logic [7:0] b,
                                      input logic sel);
    logic [7:0] src [2];
    src[0] = a;
    src[1] = b;
    return src[int'(sel)];
  endfunction

  // One rising edge; the model advances from the inputs present before the edge.
  task automatic tick();
    logic [7:0] nxt_q;
    int         nxt_cnt;
    logic       nxt_jq;
    nxt_q   = rst ? 8'h00 : pick(w_i0, w_i1, w_j);
    nxt_cnt = cnt_m;
    nxt_jq  = w_j;
    if (rst) begin
      nxt_cnt = 0;
      nxt_jq  = 1'b0;
    end else if (w_j != jq_m) begin
      nxt_cnt = (cnt_m + 1 > CNT_MAX) ? CNT_MAX : cnt_m + 1;
    end
    @(posedge clk);
    #1;
    exp_q = nxt_q;
    cnt_m = nxt_cnt;
    jq_m  = nxt_jq;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_o_q"}, w_o_q, exp_q);
`ifdef MUX2_SWITCH_CNT_EN
    check({tag, "_sw_cnt"}, 8'(w_sw_cnt), 8'(cnt_m));
`endif
  endtask

  initial begin
    logic [2:0] combo;

    // Combinational sweep over every (j, i0, i1) on the 1-bit instance.
    for (int k = 0; k < 8; k++) begin
      combo = 3'(k);
      n_j   = combo[2];
      n_i0  = combo[1];
      n_i1  = combo[0];
      #5;
      check("sweep_o", 8'(n_o), 8'(combo[2] ? combo[0] : combo[1]));
    end

    // 8-bit selection within one timestep.
    w_i0 = 8'hA5;
    w_i1 = 8'h3C;
    w_j  = 1'b0;
    #1 check("wide_j0", w_o, 8'hA5);
    w_j  = 1'b1;
    #1 check("wide_j1", w_o, 8'h3C);

    // Reset held for two edges clears the registered path.
    rst = 1'b1;
    tick();
    tick();
    check("rst_hold_o_q", w_o_q, 8'h00);
    check_regs("rst_hold");

    // Registered path lags the combinational output by one edge.
    rst  = 1'b0;
    w_j  = 1'b1;
    w_i1 = 8'hFF;
    #1;
    check("lat_o", w_o, 8'hFF);
    check("lat_o_q_before", w_o_q, 8'h00);
    tick();
    check("lat_o_q_after", w_o_q, 8'hFF);
    check_regs("lat");

    // Reset mid-stream clears o_q but leaves o alone.
    w_i1 = 8'h3C;
    tick();
    check("mid_o_q_pre", w_o_q, 8'h3C);
    rst = 1'b1;
    tick();
    check("mid_o_q_rst", w_o_q, 8'h00);
    check("mid_o_rst", w_o, 8'h3C);
    rst = 1'b0;
    tick();
    check("mid_o_q_resume", w_o_q, 8'h3C);
    check_regs("mid");

    // Five toggles after reset saturate a 2-bit counter.
    rst = 1'b1;
    w_j = 1'b0;
    tick();
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      w_j = ~w_j;
      tick();
      check_regs("toggle");
    end
`ifdef MUX2_SWITCH_CNT_EN
    check("toggle_sat", 8'(w_sw_cnt), 8'd3);
`endif
    rst = 1'b1;
    tick();
    check_regs("toggle_rst");
`ifdef MUX2_SWITCH_CNT_EN
    check("toggle_rst_zero", 8'(w_sw_cnt), 8'd0);
`endif
    rst = 1'b0;

    // Randomized cycles with occasional reset.
    for (int r = 0; r < 300; r++) begin
      w_i0 = 8'($urandom);
      w_i1 = 8'($urandom);
      w_j  = 1'($urandom);
      rst  = ($urandom_range(0, 15) == 0);
      #1;
      check("rand_o", w_o, pick(w_i0, w_i1, w_j));
      tick();
      check_regs("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
